chunked_subtractor: RTL and testbench

//  Multi-cycle subtractor with flags: computes D = A - B - borrow, CHUNK bits per clock, LSB chunk first.

---
 rtl/chunked_subtractor_pkg.sv | 27 ++
 rtl/chunked_subtractor_chunk_sub.sv | 21 ++
 rtl/chunked_subtractor.sv | 144 ++++++++++++++
 tb/tb_chunked_subtractor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/chunked_subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM encoding, chunk-count
// derivation and the flag bit positions used by the ALU flag mux.
package chunked_subtractor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sub_state_t;

  // Flag bit positions within the ALU status vector
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_S = 4;

  // Number of chunk cycles per operation
  function automatic int nch_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width, never narrower than one bit
  function automatic int idx_width_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chunked_subtractor_chunk_sub.sv
// One CHUNK-bit subtract-with-borrow slice: {bo, dif} = x - y - bi.
module chunk_sub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] dif,
  output logic             bo
);

  logic [CHUNK:0] full_s;

  // Extended-width subtraction; the top bit is the borrow out of this slice
  always_comb begin
    full_s = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
    dif    = full_s[CHUNK-1:0];
    bo     = full_s[CHUNK];
  end

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor producing AVR-style SUB/SBC/CP/CPC flags, processing
// CHUNK bits per clock starting from the least significant chunk.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             cp2,
  input  logic             rst,
  input  logic             start,
  input  logic             wc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             zi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             co,
  output logic             zo,
  output logic             no,
  output logic             vo,
  output logic             so
);

  localparam int NCH = nch_of(WIDTH, CHUNK);
  localparam int IW  = idx_width_of(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  sub_state_t       state_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] shadow_r;
  logic             wc_r;
  logic             zi_r;
  logic             borrow_r;
  logic             zacc_r;

  logic [CHUNK-1:0] x_s;
  logic [CHUNK-1:0] y_s;
  logic [CHUNK-1:0] dif_s;
  logic             bo_s;
  logic [WIDTH-1:0] res_s;
  logic             zacc_s;
  logic             last_s;
  logic             z_final_s;
  logic             v_final_s;

  // Select the operand slices for the chunk currently being processed
  always_comb begin
    x_s = a_r[int'(idx_r)*CHUNK +: CHUNK];
    y_s = b_r[int'(idx_r)*CHUNK +: CHUNK];
  end

  chunk_sub #(.CHUNK(CHUNK)) u_chunk_sub (
    .x   (x_s),
    .y   (y_s),
    .bi  (borrow_r),
    .dif (dif_s),
    .bo  (bo_s)
  );

  // Merge the new chunk into the shadow and derive the completion flags
  always_comb begin
    res_s = shadow_r;
    res_s[int'(idx_r)*CHUNK +: CHUNK] = dif_s;
    zacc_s = zacc_r & (dif_s == {CHUNK{1'b0}});
    last_s = (idx_r == LAST_IDX);
    if (wc_r) begin
      z_final_s = zacc_s & zi_r;
    end else begin
      z_final_s = zacc_s;
    end
    v_final_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ res_s[WIDTH-1]);
  end

  // Control FSM, chunk counter, operand/result registers and output flags
  always_ff @(posedge cp2) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      shadow_r <= {WIDTH{1'b0}};
      wc_r     <= 1'b0;
      zi_r     <= 1'b0;
      borrow_r <= 1'b0;
      zacc_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      d        <= {WIDTH{1'b0}};
      co       <= 1'b0;
      zo       <= 1'b0;
      no       <= 1'b0;
      vo       <= 1'b0;
      so       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            wc_r     <= wc;
            zi_r     <= zi;
            borrow_r <= wc & ci;
            idx_r    <= {IW{1'b0}};
            zacc_r   <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          shadow_r <= res_s;
          borrow_r <= bo_s;
          zacc_r   <= zacc_s;
          if (last_s) begin
            d       <= res_s;
            co      <= bo_s;
            zo      <= z_final_s;
            no      <= res_s[WIDTH-1];
            vo      <= v_final_s;
            so      <= res_s[WIDTH-1] ^ v_final_s;
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed-vector bench for chunked_subtractor with hand-computed results.
module tb_chunked_subtractor;

  logic        cp2;
  logic        rst;
  logic        start;
  logic        wc;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        zi;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        co;
  logic        zo;
  logic        no;
  logic        vo;
  logic        so;

  int total;
  int bad;

  chunked_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .cp2   (cp2),
    .rst   (rst),
    .start (start),
    .wc    (wc),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .zi    (zi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .co    (co),
    .zo    (zo),
    .no    (no),
    .vo    (vo),
    .so    (so)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  // flags packed as {S,V,N,Z,C}
  function automatic logic [4:0] flags();
    return {so, vo, no, zo, co};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait for done after the accepting edge; n counts edges after that edge
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge cp2);
      #1;
      n++;
    end while (!done && n < 20);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one operation from an idle #1-after-edge point
  task automatic launch(input logic w, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic z);
    wc = w; a = av; b = bv; ci = c; zi = z; start = 1'b1;
    @(posedge cp2);
    #1;
    start = 1'b0;
    a = 16'h5A5A; b = 16'hA5A5; ci = ~c; zi = ~z; wc = ~w;
  endtask

  task automatic op(input string tag, input logic w, input logic [15:0] av, input logic [15:0] bv,
                    input logic c, input logic z, input logic [15:0] exp_d, input logic [4:0] exp_f);
    int n;
    launch(w, av, bv, c, z);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_d"}, 32'(d), 32'(exp_d));
    chk({tag, "_flags"}, 32'(flags()), 32'(exp_f));
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; wc = 1'b0; a = 16'h0; b = 16'h0; ci = 1'b0; zi = 1'b0;
    repeat (3) @(posedge cp2);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);

    // Basic subtracts, flags {S,V,N,Z,C}
    op("t1", 1'b0, 16'h1234, 16'h0034, 1'b0, 1'b0, 16'h1200, 5'b00000);
    @(posedge cp2); #1;
    chk("t1_done_drop", 32'(done), 32'd0);
    chk("t1_hold_d", 32'(d), 32'h1200);
    op("t2", 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 5'b10101);
    op("t3v", 1'b0, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 5'b11000);
    op("t3z", 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 5'b00010);
    // With-carry mode
    op("t4z1", 1'b1, 16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, 5'b00010);
    op("t4z0", 1'b1, 16'h0005, 16'h0004, 1'b1, 1'b0, 16'h0000, 5'b00000);
    op("t4c", 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 5'b10101);

    // Start while busy is ignored
    launch(1'b0, 16'h1234, 16'h0034, 1'b0, 1'b0);
    @(posedge cp2); #1;
    wc = 1'b0; a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge cp2); #1;
    start = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("t5_lat", 32'(n), 32'd2);
    chk("t5_d", 32'(d), 32'h1200);
    chk("t5_flags", 32'(flags()), 32'd0);
    // Back-to-back: start accepted in the done cycle
    wc = 1'b0; a = 16'h0010; b = 16'h0001; ci = 1'b0; zi = 1'b0; start = 1'b1;
    @(posedge cp2); #1;
    start = 1'b0;
    chk("t5b_busy", 32'(busy), 32'd1);
    chk("t5b_done", 32'(done), 32'd0);
    chk("t5b_hold", 32'(d), 32'h1200);
    wait_done(n);
    chk("t5b_lat", 32'(n), 32'd4);
    chk("t5b_d", 32'(d), 32'h000F);

    // Reset in the middle of an operation
    launch(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b0);
    @(posedge cp2); #1;
    rst = 1'b1;
    @(posedge cp2); #1;
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_d", 32'(d), 32'd0);
    chk("t6_flags", 32'(flags()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge cp2); #1;
      chk("t6_nodone", 32'(done), 32'd0);
    end
    // Reset and start together: start is dropped
    wc = 1'b0; a = 16'h0003; b = 16'h0001; rst = 1'b1; start = 1'b1;
    @(posedge cp2); #1;
    rst = 1'b0; start = 1'b0;
    chk("t6b_busy0", 32'(busy), 32'd0);
    @(posedge cp2); #1;
    chk("t6b_busy1", 32'(busy), 32'd0);
    chk("t6b_d", 32'(d), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
